control_sequencer: RTL

- Hard-wired control unit directly upstream of DataPath.
- Runs a T-state sequence: fetch (T0–T2), then execute (T3–T5).
- Decodes the IR value the datapath returns and drives every datapath strobe: PCout, MARin, IncPC, Zlowin/out, PCin, Read, MDRin/out, IRin, Yin, register in/out enables and the ALU op select.
- Replaces the hand-sequenced stimulus used for per-instruction bring-up.

---
 rtl/control_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hard-wired T-state control unit driving the DataPath strobes.
// Defining CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state after each instruction.
module control_sequencer #(
   parameter int NUM_REGS = 16,
   parameter int IR_W     = 32
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [IR_W-1:0]     ir,
   input  logic                mem_ready,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                Zlowin,
   output logic                Zlowout,
   output logic                PCin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic [NUM_REGS-1:0] r_in,
   output logic [NUM_REGS-1:0] r_out,
   output logic [4:0]          alu_op,
   output logic                run,
   output logic                halted,
   output logic                illegal
`ifdef CTRL_SINGLE_STEP_EN
   ,
   input  logic                step
`endif
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_T0     = 4'd1;
   localparam logic [3:0] ST_T1     = 4'd2;
   localparam logic [3:0] ST_T2     = 4'd3;
   localparam logic [3:0] ST_T3     = 4'd4;
   localparam logic [3:0] ST_T4     = 4'd5;
   localparam logic [3:0] ST_T5     = 4'd6;
   localparam logic [3:0] ST_HALTED = 4'd7;
`ifdef CTRL_SINGLE_STEP_EN
   localparam logic [3:0] ST_PAUSE  = 4'd8;
   localparam logic [3:0] ST_DONE   = ST_PAUSE;
`else
   localparam logic [3:0] ST_DONE   = ST_T0;
`endif

   localparam logic [4:0] OP_NEG  = 5'h10;
   localparam logic [4:0] OP_NOT  = 5'h11;
   localparam logic [4:0] OP_NOP  = 5'h1A;
   localparam logic [4:0] OP_HALT = 5'h1B;

   logic [3:0] state_r;
   logic [3:0] state_nxt_s;
   logic       illegal_r;
   logic       illegal_nxt_s;
   logic [4:0] opcode_s;
   logic [3:0] ra_s;
   logic [3:0] rb_s;
   logic [3:0] rc_s;
   logic       is_3reg_s;
   logic       is_2reg_s;
   logic       unused_s;

   assign opcode_s  = ir[31:27];
   assign ra_s      = ir[26:23];
   assign rb_s      = ir[22:19];
   assign rc_s      = ir[18:15];
   assign is_3reg_s = (opcode_s[4:3] == 2'b00);
   assign is_2reg_s = (opcode_s == OP_NEG) || (opcode_s == OP_NOT);
   assign unused_s  = ^ir[14:0];

   // Register indices outside NUM_REGS select nothing, keeping r_in/r_out one-hot-or-zero.
   function automatic logic [NUM_REGS-1:0] reg_sel_f(input logic [3:0] idx);
      logic [NUM_REGS-1:0] sel;
      sel = {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         sel[i] = (int'(idx) == i);
      end
      return sel;
   endfunction

   // Next-state and illegal-flag decode.
   always_comb begin
      state_nxt_s   = state_r;
      illegal_nxt_s = illegal_r;
      case (state_r)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_nxt_s   = ST_T0;
               illegal_nxt_s = 1'b0;
            end else begin
               state_nxt_s   = state_r;
               illegal_nxt_s = illegal_r;
            end
         end
         ST_T0: state_nxt_s = ST_T1;
         ST_T1: begin
            if (mem_ready) begin
               state_nxt_s = ST_T2;
            end else begin
               state_nxt_s = ST_T1;
            end
         end
         ST_T2: begin
            if (is_3reg_s || is_2reg_s) begin
               state_nxt_s = ST_T3;
            end else if (opcode_s == OP_NOP) begin
               state_nxt_s = ST_DONE;
            end else if (opcode_s == OP_HALT) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s   = ST_HALTED;
               illegal_nxt_s = 1'b1;
            end
         end
         // An IR that changes class mid-execute is treated as illegal rather than guessed at.
         ST_T3: begin
            if (is_3reg_s || is_2reg_s) begin
               state_nxt_s = ST_T4;
            end else begin
               state_nxt_s   = ST_HALTED;
               illegal_nxt_s = 1'b1;
            end
         end
         ST_T4: begin
            if (is_3reg_s) begin
               state_nxt_s = ST_T5;
            end else if (is_2reg_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s   = ST_HALTED;
               illegal_nxt_s = 1'b1;
            end
         end
         ST_T5: begin
            if (is_3reg_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s   = ST_HALTED;
               illegal_nxt_s = 1'b1;
            end
         end
`ifdef CTRL_SINGLE_STEP_EN
         ST_PAUSE: begin
            if (step) begin
               state_nxt_s = ST_T0;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
`endif
         default: begin
            state_nxt_s   = ST_IDLE;
            illegal_nxt_s = 1'b0;
         end
      endcase
   end

   // State and illegal-flag registers; clear aborts immediately.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r   <= ST_IDLE;
         illegal_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         illegal_r <= illegal_nxt_s;
      end
   end

   // Strobe decode from present state and IR; alu_op stays 0 unless Zlowin carries a real op.
   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zlowin  = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      r_in    = {NUM_REGS{1'b0}};
      r_out   = {NUM_REGS{1'b0}};
      alu_op  = 5'd0;
      run     = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;
      case (state_r)
         ST_T0: begin
            run    = 1'b1;
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         ST_T1: begin
            run     = 1'b1;
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         ST_T2: begin
            run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            run = 1'b1;
            if (is_3reg_s) begin
               r_out = reg_sel_f(rb_s);
               Yin   = 1'b1;
            end else if (is_2reg_s) begin
               r_out  = reg_sel_f(rb_s);
               Zlowin = 1'b1;
               alu_op = opcode_s;
            end else begin
               r_out = {NUM_REGS{1'b0}};
            end
         end
         ST_T4: begin
            run = 1'b1;
            if (is_3reg_s) begin
               r_out  = reg_sel_f(rc_s);
               Zlowin = 1'b1;
               alu_op = opcode_s;
            end else if (is_2reg_s) begin
               Zlowout = 1'b1;
               r_in    = reg_sel_f(ra_s);
            end else begin
               r_out = {NUM_REGS{1'b0}};
            end
         end
         ST_T5: begin
            run = 1'b1;
            if (is_3reg_s) begin
               Zlowout = 1'b1;
               r_in    = reg_sel_f(ra_s);
            end else begin
               r_in = {NUM_REGS{1'b0}};
            end
         end
         ST_HALTED: begin
            halted  = 1'b1;
            illegal = illegal_r;
         end
         default: begin
            run = 1'b0;
         end
      endcase
   end

endmodule
